// File: rtl/countdown_timer.sv
// Loadable down-counting timer: N*PRESCALE cycles from start to count==0, one-cycle done pulse after.
// Control is level-sampled every edge (load > pause > start); no backpressure, outputs registered.
module countdown_timer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             start_i,
  input  logic             pause_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             expired_o
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             expired_q, expired_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    done_d  = 1'b0;

    if (load_i) begin
      // Load is also the abort path: an interrupted run never pulses done.
      count_d = load_value_i;
      presc_d = '0;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (count_q != '0) begin
              state_d = S_RUN;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (pause_i) begin
            state_d = S_PAUSED;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end
            if (count_q <= WIDTH'(1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_PAUSED: begin
          // Prescaler is kept so a resume finishes the partial tick.
          if (start_i && !pause_i) begin
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d    = (state_d == S_RUN) || (state_d == S_PAUSED);
    expired_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
    end
  end

  assign count_o   = count_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign expired_o = expired_q;

endmodule
